// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex 7-segment scan controller with a double-buffered
// byte-write path that commits at frame boundaries and per-slot blanking.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 500
) (
    input  logic              clkIN,
    input  logic              rstIN,
    input  logic              wrIN,
    input  logic [7:0]        wrDataIN,
    input  logic              blankIN,
    output logic [6:0]        segOUT,
    output logic [DIGITS-1:0] digOUT,
    output logic              pendOUT,
    output logic              frameOUT
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(PRESCALE);
    localparam int SW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [BW-1:0]     shadow_q, shadow_d;
    logic [BW-1:0]     active_q, active_d;
    logic              pend_q, pend_d;
    logic              frame_q, frame_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    logic [BW-1:0]     shadow_shift;
    logic [BW-1:0]     active_shr;
    logic [3:0]        nibble;
    logic              last_cnt;
    logic              commit;

    // With only two digits the whole shadow is replaced by the new byte.
    generate
        if (DIGITS == 2) begin : g_shift_two
            assign shadow_shift = wrDataIN;
        end else begin : g_shift_many
            assign shadow_shift = {shadow_q[BW-9:0], wrDataIN};
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1111110;
            4'h1:    hex7 = 7'b0110000;
            4'h2:    hex7 = 7'b1101101;
            4'h3:    hex7 = 7'b1111001;
            4'h4:    hex7 = 7'b0110011;
            4'h5:    hex7 = 7'b1011011;
            4'h6:    hex7 = 7'b1011111;
            4'h7:    hex7 = 7'b1110000;
            4'h8:    hex7 = 7'b1111111;
            4'h9:    hex7 = 7'b1111011;
            4'hA:    hex7 = 7'b1110111;
            4'hB:    hex7 = 7'b0011111;
            4'hC:    hex7 = 7'b0001101;
            4'hD:    hex7 = 7'b0111101;
            4'hE:    hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;

        last_cnt = (cnt_q == CNT_LAST);
        if (last_cnt) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == ST_BLANK && cnt_q == BLANK_LAST) begin
                state_d = ST_SHOW;
            end
        end

        // Outputs trail the scan registers by one edge, so the commit edge is
        // the one that ends the cycle in which frameOUT is visible.
        commit = frame_q && (pend_q || wrIN);
        if (wrIN) begin
            shadow_d = shadow_shift;
            pend_d   = 1'b1;
        end
        if (commit) begin
            active_d = shadow_d;
            pend_d   = 1'b0;
        end

        frame_d    = (slot_q == SLOT_LAST) && last_cnt;
        active_shr = active_q >> {slot_q, 2'b00};
        nibble     = active_shr[3:0];

        seg_d = '0;
        dig_d = '0;
        if (state_q == ST_SHOW && !blankIN) begin
            seg_d = hex7(nibble);
            dig_d = {{(DIGITS-1){1'b0}}, 1'b1} << slot_q;
        end
    end

    always_ff @(posedge clkIN or posedge rstIN) begin
        if (rstIN) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            slot_q   <= '0;
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            frame_q  <= 1'b0;
            seg_q    <= '0;
            dig_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign segOUT   = seg_q;
    assign digOUT   = dig_q;
    assign pendOUT  = pend_q;
    assign frameOUT = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random writes
// and blanking, compared against a cycle-indexed frame model.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wrData;
    logic       blank;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       pend;
    logic       frame;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK   (BLANK)
    ) dut (
        .clkIN   (clk),
        .rstIN   (rst),
        .wrIN    (wr),
        .wrDataIN(wrData),
        .blankIN (blank),
        .segOUT  (seg),
        .digOUT  (dig),
        .pendOUT (pend),
        .frameOUT(frame)
    );

    logic [6:0] hexTable [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: cycle index since reset release and the buffers.
    int          cyc;
    logic [15:0] shadowM;
    logic [15:0] activeM;
    bit          pendM;
    bit          frameM;
    logic [6:0]  expSeg;
    logic [3:0]  expDig;
    logic [3:0]  lastDig;
    int          zeroRun;
    bit          seenEnable;
    int          lastFrameCyc;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        cyc          = 0;
        shadowM      = '0;
        activeM      = '0;
        pendM        = 1'b0;
        frameM       = 1'b0;
        zeroRun      = 0;
        seenEnable   = 1'b0;
        lastDig      = '0;
        lastFrameCyc = -1;
    endtask

    // Called right after a falling edge; asserts reset between clock edges.
    task automatic resetDut();
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_seg", seg, 7'd0);
        checkOutput("rst_dig", dig, 4'd0);
        checkOutput("rst_pend", pend, 1'b0);
        checkOutput("rst_frame", frame, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    // One clock: drive inputs, advance the model, check at the falling edge.
    task automatic applyStimulus(input bit w, input logic [7:0] d, input bit b);
        int         pos;
        int         slot;
        int         cnt;
        bit         commit;
        logic [3:0] nib;
        wr     = w;
        wrData = d;
        blank  = b;
        @(posedge clk);
        pos    = cyc % FRAME;
        slot   = pos / PRESCALE;
        cnt    = pos % PRESCALE;
        expSeg = '0;
        expDig = '0;
        if (cnt >= BLANK && !b) begin
            nib    = 4'(activeM >> (4 * slot));
            expDig = 4'(1 << slot);
            expSeg = hexTable[nib];
        end
        commit = frameM && (pendM || w);
        if (w) begin
            shadowM = {shadowM[7:0], d};
            pendM   = 1'b1;
        end
        if (commit) begin
            activeM = shadowM;
            pendM   = 1'b0;
        end
        frameM = (pos == FRAME - 1);
        cyc++;
        @(negedge clk);
        checkOutput("seg", seg, expSeg);
        checkOutput("dig", dig, expDig);
        checkOutput("pend", pend, pendM);
        checkOutput("frame", frame, frameM);
        checkOutput("dig_onehot0", $onehot0(dig), 1);
        if (dig != 0) begin
            if (seenEnable && dig != lastDig) begin
                checkOutput("dig_gap", zeroRun >= BLANK, 1);
            end
            seenEnable = 1'b1;
            lastDig    = dig;
            zeroRun    = 0;
        end else begin
            zeroRun++;
        end
        if (frame) begin
            if (lastFrameCyc >= 0) begin
                checkOutput("frame_period", cyc - lastFrameCyc, FRAME);
            end
            lastFrameCyc = cyc;
        end
    endtask

    bit         rw;
    bit         rb;
    logic [7:0] rd;

    initial begin
        rst    = 1'b1;
        wr     = 1'b0;
        wrData = '0;
        blank  = 1'b0;
        modelReset();
        @(negedge clk);
        resetDut();

        // Frame 1: two writes mid-frame, digit 0 still shows '0'.
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(i == 6 || i == 10, (i == 6) ? 8'h3A : 8'h5F, 1'b0);
            if (i == 2) begin
                checkOutput("first_dig", dig, 4'b0001);
                checkOutput("first_seg", seg, 7'b1111110);
            end
        end

        // Frame 2: committed 0x3A5F is on display.
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (i == 2) checkOutput("d0_is_F", seg, 7'b1000111);
            if (i == 26) checkOutput("d3_is_3", seg, 7'b1111001);
        end

        // Frame 3: write landing on the commit cycle.
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(i == 0, 8'h81, 1'b0);
            if (i == 0) checkOutput("commit_wr_pend", pend, 1'b0);
            if (i == 2) checkOutput("d0_is_1", seg, 7'b0110000);
            if (i == 10) checkOutput("d1_is_8", seg, 7'b1111111);
        end

        // Frame 4: blanked throughout, with a write that still commits.
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(i == 12, 8'hC4, 1'b1);
        end

        // Frame 5: write, then reset in the middle of slot 2.
        for (int i = 0; i <= 20; i++) begin
            applyStimulus(i == 1, 8'h77, 1'b0);
        end
        resetDut();
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (i == 2) checkOutput("post_rst_d0", seg, 7'b1111110);
        end

        // Random writes and blanking over ten frames, with one reset.
        for (int i = 0; i < 10 * FRAME; i++) begin
            rw = ($urandom_range(0, 4) == 0);
            rb = ($urandom_range(0, 9) == 0);
            rd = 8'($urandom);
            if (i == 150) resetDut();
            applyStimulus(rw, rd, rb);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
